// File: rtl/dec8_conv_sched_pkg.sv
// Shared types and constants for the 8-digit BCD conversion scheduler.
package dec8_conv_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ARM   = 3'd2,
    S_BUSY  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [31:0] DEC8_MAX = 32'd99_999_999;
  localparam logic [31:0] ERR_CODE = 32'h9999_9999;

  // Largest channel count addressable by the 3-bit channel index.
  localparam int unsigned CH_MAX = 8;

endpackage

// File: rtl/dec8_conv_sched_rr_arb.sv
// NCH-wide combinational round-robin arbiter: search begins one past i_last.
module rr_arb #(
  parameter int unsigned NCH = 4
) (
  input  logic [NCH-1:0] i_req,
  input  logic [2:0]     i_last,
  output logic [NCH-1:0] o_gnt,
  output logic [2:0]     o_gnt_idx,
  output logic           o_gnt_vld
);

  logic [2:0] w_c;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_gnt_vld = 1'b0;
    w_c       = '0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      w_c = 3'((32'(i_last) + k) % NCH);
      // Masked reduction avoids a variable bit-select narrower than the index.
      if (!o_gnt_vld && (|(i_req & (NCH'(1) << w_c)))) begin
        o_gnt     = NCH'(1) << w_c;
        o_gnt_idx = w_c;
        o_gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dec8_conv_sched.sv
// Round-robin scheduler sharing one serial binary-to-BCD converter among NCH requesters.
// Optional watchdog on the converter run: define SCHED_TIMEOUT_EN.
module dec8_conv_sched
  import dec8_conv_sched_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned DW  = 27,
  parameter int unsigned TMO = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*DW-1:0] din,
  output logic [NCH-1:0]    ack,
  output logic [31:0]       dout,
  output logic              dout_vld,
  output logic [2:0]        dout_ch,
  output logic              dout_err,
  output logic              busy,
  output logic              conv_st,
  output logic [DW-1:0]     conv_din,
  input  logic [3:0]        conv_ptr,
  input  logic [31:0]       conv_ddec
);

  if (NCH < 2 || NCH > CH_MAX || DW < 1 || DW > 32 || TMO < 1 || TMO > 255) begin : g_bad_cfg
    $error("dec8_conv_sched: parameter out of range");
  end

  state_t            r_state;
  logic [2:0]        r_rr;
  logic [2:0]        r_grant;
  logic [NCH-1:0]    r_gnt_oh;
  logic [31:0]       r_dout;
  logic [2:0]        r_dout_ch;
  logic              r_dout_err;
  logic [DW-1:0]     r_conv_din;

  logic [NCH-1:0]    w_gnt;
  logic [2:0]        w_gnt_idx;
  logic              w_gnt_vld;
  logic [DW-1:0]     w_opnd;
  logic              w_oor;
  logic              w_wd_hit;

  rr_arb #(.NCH(NCH)) u_arb (
    .i_req     (req),
    .i_last    (r_rr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_vld (w_gnt_vld)
  );

  always_comb begin
    w_opnd = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (w_gnt_idx == 3'(i)) w_opnd = din[i*DW +: DW];
    end
  end

  assign w_oor = 32'(w_opnd) > DEC8_MAX;

`ifdef SCHED_TIMEOUT_EN
  logic [7:0] r_wd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd <= '0;
    end else if (r_state == S_START) begin
      r_wd <= '0;
    end else if (r_state == S_ARM || r_state == S_BUSY) begin
      r_wd <= r_wd + 8'd1;
    end
  end

  // Fires on the TMO-th clock spent in ARM/BUSY.
  assign w_wd_hit = (r_state == S_ARM || r_state == S_BUSY) && (r_wd == 8'(TMO - 1));
`else
  assign w_wd_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rr       <= 3'(NCH - 1);
      r_grant    <= '0;
      r_gnt_oh   <= '0;
      r_dout     <= '0;
      r_dout_ch  <= '0;
      r_dout_err <= 1'b0;
      r_conv_din <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_grant    <= w_gnt_idx;
            r_gnt_oh   <= w_gnt;
            r_rr       <= w_gnt_idx;
            r_conv_din <= w_opnd;
            if (w_oor) begin
              r_dout     <= ERR_CODE;
              r_dout_ch  <= w_gnt_idx;
              r_dout_err <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_state <= S_START;
            end
          end
        end
        S_START: r_state <= S_ARM;
        S_ARM: begin
          if (w_wd_hit) begin
            r_dout     <= '0;
            r_dout_ch  <= r_grant;
            r_dout_err <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (conv_ptr == 4'd0) begin
            r_dout     <= conv_ddec;
            r_dout_ch  <= r_grant;
            r_dout_err <= 1'b0;
            r_state    <= S_DONE;
          end else if (w_wd_hit) begin
            r_dout     <= '0;
            r_dout_ch  <= r_grant;
            r_dout_err <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Result registers are loaded on entry to DONE so they are valid with the pulse.
  assign dout     = r_dout;
  assign dout_ch  = r_dout_ch;
  assign dout_err = r_dout_err;
  assign dout_vld = (r_state == S_DONE);
  assign ack      = (r_state == S_DONE) ? r_gnt_oh : '0;
  assign busy     = (r_state != S_IDLE);
  assign conv_st  = (r_state == S_START);
  assign conv_din = r_conv_din;

endmodule

// File: tb/tb_dec8_conv_sched.sv
// Directed scoreboard bench for dec8_conv_sched with a behavioural serial converter model.
module tb_dec8_conv_sched;

  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = 27;
  localparam int unsigned TMO = 255;

  typedef struct packed {
    logic [2:0]  ch;
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    req = '0;
  logic [NCH*DW-1:0] din = '0;
  logic [NCH-1:0]    ack;
  logic [31:0]       dout;
  logic              dout_vld;
  logic [2:0]        dout_ch;
  logic              dout_err;
  logic              busy;
  logic              conv_st;
  logic [DW-1:0]     conv_din;
  logic [3:0]        conv_ptr = '0;
  logic [31:0]       conv_ddec = '0;

  logic              stuck = 1'b0;
  logic [DW-1:0]     m_op = '0;
  logic [NCH-1:0]    hold = '0;
  exp_t              sb[$];
  int                n_chk = 0;
  int                n_err = 0;
  int                last_lat = 0;

  always #5 clk = ~clk;

  dec8_conv_sched #(.NCH(NCH), .DW(DW), .TMO(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .din       (din),
    .ack       (ack),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .dout_ch   (dout_ch),
    .dout_err  (dout_err),
    .busy      (busy),
    .conv_st   (conv_st),
    .conv_din  (conv_din),
    .conv_ptr  (conv_ptr),
    .conv_ddec (conv_ddec)
  );

  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r = r | (32'(x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  // Serial converter model: pointer loads 8 after conv_st, counts down, result appears at 0.
  always @(posedge clk) begin
    if (conv_st) begin
      conv_ptr  <= 4'd8;
      m_op      <= conv_din;
      conv_ddec <= 32'hDEAD_BEEF;
    end else if (conv_ptr != 4'd0 && !(stuck && conv_ptr == 4'd5)) begin
      conv_ptr <= conv_ptr - 4'd1;
      if (conv_ptr == 4'd1) conv_ddec <= to_bcd(32'(m_op));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int ch, input int unsigned v, input logic e, input logic [31:0] d);
    exp_t x;
    din[ch*DW +: DW] = DW'(v);
    req[ch] = 1'b1;
    x.ch = 3'(ch);
    x.d  = d;
    x.e  = e;
    sb.push_back(x);
  endtask

  // Wait for n result pulses, scoring each against the queue; drops non-held reqs on ack.
  task automatic run(input int n_acks, input int exp_st, input int budget);
    int   got;
    int   st;
    int   t;
    int   st_t;
    exp_t x;
    got = 0; st = 0; t = 0; st_t = 0;
    while (got < n_acks && t < budget) begin
      @(negedge clk);
      t++;
      if (conv_st) begin
        st++;
        st_t = t;
      end
      if (dout_vld) begin
        got++;
        last_lat = t - st_t;
        n_chk++;
        assert (sb.size() != 0) else begin
          n_err++;
          $error("FAIL sb_underflow observed=%0d expected=>0", sb.size());
        end
        if (sb.size() != 0) begin
          x = sb.pop_front();
          chk("dout_ch", 32'(dout_ch), 32'(x.ch));
          chk("dout", dout, x.d);
          chk("dout_err", 32'(dout_err), 32'(x.e));
          chk("ack", 32'(ack), 32'(1) << x.ch);
        end
        req = req & ~(ack & ~hold);
      end
    end
    chk("acks_seen", 32'(got), 32'(n_acks));
    chk("conv_st_cnt", 32'(st), 32'(exp_st));
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_ack"}, 32'(ack), 32'd0);
    chk({pfx, "_vld"}, 32'(dout_vld), 32'd0);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
    chk({pfx, "_conv_st"}, 32'(conv_st), 32'd0);
    chk({pfx, "_conv_din"}, 32'(conv_din), 32'd0);
    chk({pfx, "_dout"}, dout, 32'd0);
    chk({pfx, "_dout_ch"}, 32'(dout_ch), 32'd0);
    chk({pfx, "_dout_err"}, 32'(dout_err), 32'd0);
  endtask

  initial begin
    int t;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    drive(0, 12_345_678, 1'b0, 32'h1234_5678);
    run(1, 1, 40);
    repeat (3) @(negedge clk);
    chk("dout_hold", dout, 32'h1234_5678);
    chk("vld_idle", 32'(dout_vld), 32'd0);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    hold = '1;
    drive(0, 1, 1'b0, 32'h0000_0001);
    drive(1, 22, 1'b0, 32'h0000_0022);
    drive(2, 333, 1'b0, 32'h0000_0333);
    drive(3, 4444, 1'b0, 32'h0000_4444);
    sb.push_back('{ch: 3'd0, d: 32'h0000_0001, e: 1'b0});
    run(5, 5, 120);
    req  = '0;
    hold = '0;
    @(negedge clk);

    drive(1, 100_000_000, 1'b1, 32'h9999_9999);
    run(1, 0, 20);

    drive(2, 0, 1'b0, 32'h0000_0000);
    run(1, 1, 40);
    drive(3, 99_999_999, 1'b0, 32'h9999_9999);
    run(1, 1, 40);

    din[2*DW +: DW] = DW'(555);
    req[2] = 1'b1;
    t = 0;
    while (!conv_st && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("midrun_started", 32'(conv_st), 32'd1);
    repeat (4) @(negedge clk);
    chk("midrun_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    req   = '0;
    #1;
    chk_reset_vals("midrun");
    repeat (2) @(negedge clk);
    chk("midrun_no_ack", 32'(ack), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1, 87_654_321, 1'b0, 32'h8765_4321);
    run(1, 1, 40);

`ifdef SCHED_TIMEOUT_EN
    stuck = 1'b1;
    drive(0, 42, 1'b1, 32'h0000_0000);
    run(1, 1, 400);
    chk("wd_latency_ok", 32'(last_lat >= int'(TMO) && last_lat <= int'(TMO) + 2), 32'd1);
    @(negedge clk);
    chk("wd_idle", 32'(busy), 32'd0);
    stuck = 1'b0;
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
